bank_rr_arbiter: RTL and testbench
==================================

BANK_RR_ARBITER -- requirements
Module: bank_rr_arbiter

Interface
REQ-001 Parameter NUM_CORES, 16, number of requesting cores (2..32).
REQ-002 Parameter BANK_ID_W, 4, bank-select field width in each core address.
REQ-003 Parameter ROW_W, 8, bank-local address width.
REQ-004 Parameter DATA_W, 8, data width per core.
REQ-005 Parameter TIMEOUT, 255, max cycles waiting for b_done; 0 disables the timeout.
REQ-006 Derived AW = BANK_ID_W+ROW_W; IDX_W = clog2(NUM_CORES).
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 bank_n  in  BANK_ID_W  ID of the bank this arbiter owns.
REQ-010 req_rd  in  NUM_CORES  per-core read request, level.
REQ-011 req_wr  in  NUM_CORES  per-core write request, level.
REQ-012 addr_in  in  NUM_CORES*AW  core i at [i*AW +: AW]; bank ID in upper BANK_ID_W bits, row in lower ROW_W bits.
REQ-013 data_in  in  NUM_CORES*DATA_W  core i write data at [i*DATA_W +: DATA_W].
REQ-014 data_out  out  NUM_CORES*DATA_W  registered per-core read data, same slicing.
REQ-015 finish  out  NUM_CORES  one-cycle per-core completion pulse.
REQ-016 timeout_err  out  1  one-cycle pulse coinciding with a timed-out finish.
REQ-017 busy  out  1  high when state != IDLE.
REQ-018 b_read, b_write  out  1 each  bank command strobes.
REQ-019 b_addr  out  ROW_W; b_wdata  out  DATA_W  latched command address/data.
REQ-020 b_rdata  in  DATA_W; b_done  in  1  bank read data and completion.

Function
REQ-021 eligible[i] = (req_rd[i]|req_wr[i]) & (bank field of core i == bank_n) & !finish[i].
REQ-022 If req_rd[i] and req_wr[i] are both high, the op is a write.
REQ-023 FSM states IDLE, ISSUE, WAIT; all outputs registered.
REQ-024 IDLE: if any eligible, grant the first eligible index at or after ptr (wrapping NUM_CORES-1 -> 0); latch index g, op, row, wdata; go ISSUE. Otherwise stay.
REQ-025 ISSUE: b_read or b_write high for exactly this one cycle per the latched op; b_addr/b_wdata hold latched values from ISSUE until return to IDLE.
REQ-026 b_done is sampled in ISSUE and WAIT, ignored in IDLE; ISSUE without b_done -> WAIT.
REQ-027 On b_done sampled: for a read, data_out slot g <= b_rdata; finish[g] <= 1 for one cycle; ptr <= (g+1) mod NUM_CORES; state <= IDLE.
REQ-028 Minimum latency: request eligible in IDLE at cycle t -> strobe at t+1 -> finish at t+2 with a same-cycle b_done.
REQ-029 Writes and non-granted slots leave data_out unchanged.
REQ-030 Wait counter clears on entry to ISSUE and increments each WAIT cycle; reaching TIMEOUT without b_done: finish[g] pulse, timeout_err pulse, read slot g <= all ones, ptr advances, IDLE.
REQ-031 Changes to requests, addr_in, data_in, or bank_n after the grant do not affect the transaction in flight; a withdrawn request still completes and receives finish.
REQ-032 Exactly one transaction is outstanding at a time; at most one finish bit is high per cycle.

Reset
REQ-033 Reset is synchronous and active-high and takes effect mid-transaction: state IDLE, ptr 0, counter 0.
REQ-034 Reset values: data_out 0, finish 0, timeout_err 0, busy 0, b_read 0, b_write 0, b_addr 0, b_wdata 0.

Verification
REQ-035 Core 3 read, bank field == bank_n, b_done one cycle after b_read, b_rdata 0xA5 -> b_read pulse with core 3 row, finish[3] single pulse, data_out[31:24] = 0xA5.
REQ-036 Cores 0, 5, 15 requesting continuously, bank acks immediately -> grant order 0, 5, 15, 0; no core served twice while another waits.
REQ-037 Core 2 request with bank field != bank_n -> no strobe, finish stays 0, busy stays 0.
REQ-038 TIMEOUT=4, core 7 read, b_done never asserted -> after 4 WAIT cycles finish[7] and timeout_err pulse together, data_out slot 7 = 0xFF.
REQ-039 Core 1 write 0x3C with req_rd also high, bank asserts b_done after 3 cycles -> b_write (not b_read), b_wdata 0x3C, data_out slot 1 unchanged, finish[1] pulse.
REQ-040 Reset asserted in WAIT -> next cycle IDLE, all outputs at reset values; a later b_done is ignored.

Source files
------------

// File: rtl/bank_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bank_rr_arbiter_if
//   Command/response bus between a bank arbiter and the memory bank it owns.
//   The arbiter (master) issues one read or write command at a time; the bank
//   (slave) answers with b_done, plus b_rdata for a read.
//
//   b_read   master -> bank  one-cycle read command strobe
//   b_write  master -> bank  one-cycle write command strobe
//   b_addr   master -> bank  bank-local row, held for the whole transaction
//   b_wdata  master -> bank  write data, held for the whole transaction
//   b_rdata  bank -> master  read data, valid with b_done
//   b_done   bank -> master  command completion
// ---------------------------------------------------------------------------
interface bank_rr_arbiter_if #(
   parameter int ROW_W  = 8,
   parameter int DATA_W = 8
);
   logic              b_read;
   logic              b_write;
   logic [ROW_W-1:0]  b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic [DATA_W-1:0] b_rdata;
   logic              b_done;

   modport master (
      output b_read, b_write, b_addr, b_wdata,
      input  b_rdata, b_done
   );

   modport slave (
      input  b_read, b_write, b_addr, b_wdata,
      output b_rdata, b_done
   );
endinterface

// File: rtl/bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bank_rr_arbiter
//   Round-robin arbiter that lets NUM_CORES cores share one memory bank.
//   A core competes when it raises a read or write request whose address
//   bank field equals bank_n. One transaction is in flight at a time; the
//   winner gets a one-cycle finish pulse when the bank answers or when the
//   wait exceeds TIMEOUT cycles (then timeout_err pulses too and a read
//   returns all ones). The round-robin pointer moves past each served core.
//
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   bank_n       ID of the bank owned by this arbiter
//   req_rd/wr    per-core level requests (both high means write)
//   addr_in      per-core {bank, row} address, core i at [i*AW +: AW]
//   data_in      per-core write data, core i at [i*DATA_W +: DATA_W]
//   data_out     registered per-core read data, same slicing as data_in
//   finish       per-core one-cycle completion pulse
//   timeout_err  one-cycle pulse alongside a timed-out finish
//   busy         high while a transaction is in flight
//   bank         command/response bus to the bank (master side)
// ---------------------------------------------------------------------------
module bank_rr_arbiter #(
   parameter int NUM_CORES = 16,
   parameter int BANK_ID_W = 4,
   parameter int ROW_W     = 8,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [BANK_ID_W-1:0]                   bank_n,
   input  logic [NUM_CORES-1:0]                   req_rd,
   input  logic [NUM_CORES-1:0]                   req_wr,
   input  logic [NUM_CORES*(BANK_ID_W+ROW_W)-1:0] addr_in,
   input  logic [NUM_CORES*DATA_W-1:0]            data_in,
   output logic [NUM_CORES*DATA_W-1:0]            data_out,
   output logic [NUM_CORES-1:0]                   finish,
   output logic                                   timeout_err,
   output logic                                   busy,
   bank_rr_arbiter_if.master                      bank
);

   localparam int AW    = BANK_ID_W + ROW_W;
   localparam int IDX_W = $clog2(NUM_CORES);
   localparam int SW    = IDX_W + 1;
   // The counter only has to reach TIMEOUT-1; keep at least one bit.
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t state_q, state_d;

   logic [NUM_CORES-1:0] eligible;
   logic [ROW_W-1:0]     core_row   [NUM_CORES];
   logic [DATA_W-1:0]    core_wdata [NUM_CORES];
   logic [DATA_W-1:0]    rdata_q    [NUM_CORES];

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] g_q;
   logic             op_wr_q;
   logic [CNT_W-1:0] cnt_q;

   logic              b_read_q;
   logic              b_write_q;
   logic [ROW_W-1:0]  b_addr_q;
   logic [DATA_W-1:0] b_wdata_q;

   logic             found;
   logic [IDX_W-1:0] pick;
   logic [SW-1:0]    cand_sum;
   logic             grant;
   logic             complete;
   logic             timed_out;

   // Per-core slicing of the flat buses. A core whose finish pulse is
   // showing sits out one cycle so the pointer has moved before it returns.
   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      assign eligible[i]   = (req_rd[i] | req_wr[i])
                             && (addr_in[i*AW+ROW_W +: BANK_ID_W] == bank_n)
                             && !finish[i];
      assign core_row[i]   = addr_in[i*AW +: ROW_W];
      assign core_wdata[i] = data_in[i*DATA_W +: DATA_W];
      assign data_out[i*DATA_W +: DATA_W] = rdata_q[i];
   end

   assign bank.b_read  = b_read_q;
   assign bank.b_write = b_write_q;
   assign bank.b_addr  = b_addr_q;
   assign bank.b_wdata = b_wdata_q;

   // First eligible core at or after the pointer, wrapping modulo NUM_CORES.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      cand_sum = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         cand_sum = {1'b0, ptr_q} + SW'(k);
         if (cand_sum >= SW'(NUM_CORES)) begin
            cand_sum = cand_sum - SW'(NUM_CORES);
         end
         if (!found && eligible[cand_sum[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = cand_sum[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // b_done is only looked at once a command has been issued.
   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      complete  = 1'b0;
      timed_out = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (bank.b_done) begin
               complete = 1'b1;
               state_d  = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bank.b_done) begin
               complete = 1'b1;
               state_d  = IDLE;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               complete  = 1'b1;
               timed_out = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q       <= '0;
         g_q         <= '0;
         op_wr_q     <= 1'b0;
         cnt_q       <= '0;
         finish      <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         b_read_q    <= 1'b0;
         b_write_q   <= 1'b0;
         b_addr_q    <= '0;
         b_wdata_q   <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            rdata_q[i] <= '0;
         end
      end else begin
         finish      <= '0;
         timeout_err <= 1'b0;
         b_read_q    <= 1'b0;
         b_write_q   <= 1'b0;
         busy        <= (state_d != IDLE);

         // Everything the transaction needs is captured here, so later
         // changes on the core side cannot disturb it.
         if (grant) begin
            g_q       <= pick;
            op_wr_q   <= req_wr[pick];
            b_write_q <= req_wr[pick];
            b_read_q  <= !req_wr[pick];
            b_addr_q  <= core_row[pick];
            b_wdata_q <= core_wdata[pick];
            cnt_q     <= '0;
         end

         if (state_q == WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (complete) begin
            finish[g_q] <= 1'b1;
            timeout_err <= timed_out;
            ptr_q       <= (g_q == IDX_W'(NUM_CORES - 1)) ? '0 : g_q + IDX_W'(1);
            if (!op_wr_q) begin
               rdata_q[g_q] <= timed_out ? '1 : bank.b_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bank_rr_arbiter
//   Directed scenarios plus a randomized run against a transaction-level
//   reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_bank_rr_arbiter;

   localparam int N  = 16;
   localparam int BW = 4;
   localparam int RW = 8;
   localparam int DW = 8;
   localparam int TO = 4;
   localparam int AW = BW + RW;

   logic            clock = 1'b0;
   logic            reset;
   logic [BW-1:0]   bank_n;
   logic [N-1:0]    req_rd;
   logic [N-1:0]    req_wr;
   logic [N*AW-1:0] addr_in;
   logic [N*DW-1:0] data_in;
   logic [N*DW-1:0] data_out;
   logic [N-1:0]    finish;
   logic            timeout_err;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   bank_rr_arbiter_if #(.ROW_W(RW), .DATA_W(DW)) bif();

   bank_rr_arbiter #(
      .NUM_CORES(N), .BANK_ID_W(BW), .ROW_W(RW), .DATA_W(DW), .TIMEOUT(TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bank_n      (bank_n),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .addr_in     (addr_in),
      .data_in     (data_in),
      .data_out    (data_out),
      .finish      (finish),
      .timeout_err (timeout_err),
      .busy        (busy),
      .bank        (bif)
   );

   always #5 clock = ~clock;

   // Reference model: one in-flight transaction with an age counted from
   // its strobe cycle, the round-robin pointer and the per-core read data.
   bit            m_busy;
   int            m_core;
   bit            m_wr;
   logic [RW-1:0] m_row;
   logic [DW-1:0] m_wdata;
   int            m_age;
   int            m_ptr;
   logic [DW-1:0] m_data [N];
   int            m_fin;
   bit            m_to;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      req_rd      = '0;
      req_wr      = '0;
      addr_in     = '0;
      data_in     = '0;
      bif.b_done  = 1'b0;
      bif.b_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_core(input int i, input logic [BW-1:0] bk,
                           input logic [RW-1:0] row, input logic [DW-1:0] wd);
      addr_in[i*AW +: AW] = {bk, row};
      data_in[i*DW +: DW] = wd;
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_step();
      int fin_prev;
      fin_prev = m_fin;
      m_fin    = -1;
      m_to     = 1'b0;
      if (reset) begin
         m_busy  = 1'b0;
         m_ptr   = 0;
         m_age   = 0;
         m_row   = '0;
         m_wdata = '0;
         for (int k = 0; k < N; k++) m_data[k] = '0;
         return;
      end
      if (m_busy) begin
         if (bif.b_done || (TO != 0 && m_age == TO)) begin
            m_to   = !bif.b_done;
            m_fin  = m_core;
            m_ptr  = (m_core + 1) % N;
            m_busy = 1'b0;
            if (!m_wr) m_data[m_core] = m_to ? {DW{1'b1}} : bif.b_rdata;
         end else begin
            m_age++;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if ((req_rd[i] || req_wr[i]) && addr_in[i*AW+RW +: BW] == bank_n
                && i != fin_prev) begin
               m_busy  = 1'b1;
               m_core  = i;
               m_wr    = req_wr[i];
               m_row   = addr_in[i*AW +: RW];
               m_wdata = data_in[i*DW +: DW];
               m_age   = 0;
               break;
            end
         end
      end
   endtask

   task automatic test_reset();
      bank_n = 4'h2;
      do_reset();
      n_checks++;
      if (data_out !== '0) begin
         n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out);
      end
      n_checks++;
      if (finish !== '0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: finish=%h timeout_err=%b busy=%b want 0/0/0",
                  finish, timeout_err, busy);
      end
      n_checks++;
      if (bif.b_read !== 1'b0 || bif.b_write !== 1'b0 || bif.b_addr !== '0 || bif.b_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_bank_bus: rd=%b wr=%b addr=%h wdata=%h want all 0",
                  bif.b_read, bif.b_write, bif.b_addr, bif.b_wdata);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      set_core(3, 4'h2, 8'h5A, 8'h00);
      req_rd[3] = 1'b1;
      tick();
      req_rd[3] = 1'b0;
      n_checks++;
      if (bif.b_read !== 1'b1 || bif.b_write !== 1'b0 || bif.b_addr !== 8'h5A || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL read_strobe: rd=%b wr=%b addr=%h busy=%b want 1/0/5a/1",
                  bif.b_read, bif.b_write, bif.b_addr, busy);
      end
      tick();
      n_checks++;
      if (bif.b_read !== 1'b0 || finish !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL read_wait: rd=%b finish=%h busy=%b want 0/0/1", bif.b_read, finish, busy);
      end
      bif.b_done  = 1'b1;
      bif.b_rdata = 8'hA5;
      tick();
      bif.b_done = 1'b0;
      n_checks++;
      if (finish !== 16'h0008 || data_out[31:24] !== 8'hA5 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL read_finish: finish=%h slot3=%h busy=%b want 0008/a5/0",
                  finish, data_out[31:24], busy);
      end
      tick();
      n_checks++;
      if (finish !== '0 || data_out[31:24] !== 8'hA5) begin
         n_fail++;
         $display("FAIL read_pulse_end: finish=%h slot3=%h want 0000/a5", finish, data_out[31:24]);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_order[4] = '{0, 5, 15, 0};
      int budget;
      int got;
      do_reset();
      set_core(0, 4'h2, 8'h10, 8'h00);
      set_core(5, 4'h2, 8'h15, 8'h00);
      set_core(15, 4'h2, 8'h1F, 8'h00);
      req_rd[0]   = 1'b1;
      req_rd[5]   = 1'b1;
      req_rd[15]  = 1'b1;
      bif.b_done  = 1'b1;
      bif.b_rdata = 8'h11;
      budget = 0;
      while (order.size() < 4 && budget < 40) begin
         tick();
         budget++;
         if (bif.b_read === 1'b1) order.push_back(int'(bif.b_addr) - 16);
      end
      n_checks++;
      if (order.size() != 4) begin
         n_fail++; $display("FAIL rr_grant_count: got %0d grants want 4", order.size());
      end
      for (int k = 0; k < 4; k++) begin
         got = (k < order.size()) ? order[k] : -1;
         n_checks++;
         if (got != exp_order[k]) begin
            n_fail++; $display("FAIL rr_order[%0d]: got core %0d want core %0d", k, got, exp_order[k]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_wrong_bank();
      do_reset();
      set_core(2, 4'h3, 8'h22, 8'h00);
      req_rd[2]  = 1'b1;
      bif.b_done = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         n_checks++;
         if (bif.b_read !== 1'b0 || bif.b_write !== 1'b0 || finish !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_bank cycle %0d: rd=%b wr=%b finish=%h busy=%b want all 0",
                     c, bif.b_read, bif.b_write, finish, busy);
         end
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      set_core(7, 4'h2, 8'h77, 8'h00);
      req_rd[7] = 1'b1;
      tick();
      req_rd[7] = 1'b0;
      n_checks++;
      if (bif.b_read !== 1'b1 || bif.b_addr !== 8'h77) begin
         n_fail++; $display("FAIL to_strobe: rd=%b addr=%h want 1/77", bif.b_read, bif.b_addr);
      end
      for (int w = 1; w <= TO; w++) begin
         tick();
         n_checks++;
         if (finish !== '0 || timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_wait %0d: finish=%h terr=%b busy=%b want 0/0/1", w, finish, timeout_err, busy);
         end
      end
      tick();
      n_checks++;
      if (finish !== 16'h0080 || timeout_err !== 1'b1 || data_out[63:56] !== 8'hFF) begin
         n_fail++;
         $display("FAIL to_expire: finish=%h terr=%b slot7=%h want 0080/1/ff",
                  finish, timeout_err, data_out[63:56]);
      end
      tick();
      n_checks++;
      if (timeout_err !== 1'b0 || finish !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL to_after: terr=%b finish=%h busy=%b want 0/0/0", timeout_err, finish, busy);
      end
   endtask

   task automatic test_write_priority();
      do_reset();
      set_core(1, 4'h2, 8'h11, 8'h3C);
      req_rd[1] = 1'b1;
      req_wr[1] = 1'b1;
      tick();
      req_rd[1] = 1'b0;
      req_wr[1] = 1'b0;
      set_core(1, 4'h2, 8'hEE, 8'h99);
      n_checks++;
      if (bif.b_write !== 1'b1 || bif.b_read !== 1'b0 || bif.b_wdata !== 8'h3C || bif.b_addr !== 8'h11) begin
         n_fail++;
         $display("FAIL wr_strobe: wr=%b rd=%b wdata=%h addr=%h want 1/0/3c/11",
                  bif.b_write, bif.b_read, bif.b_wdata, bif.b_addr);
      end
      tick();
      n_checks++;
      if (bif.b_write !== 1'b0 || bif.b_wdata !== 8'h3C || bif.b_addr !== 8'h11) begin
         n_fail++;
         $display("FAIL wr_hold: wr=%b wdata=%h addr=%h want 0/3c/11", bif.b_write, bif.b_wdata, bif.b_addr);
      end
      tick();
      tick();
      bif.b_done  = 1'b1;
      bif.b_rdata = 8'h5F;
      tick();
      bif.b_done = 1'b0;
      n_checks++;
      if (finish !== 16'h0002 || data_out[15:8] !== 8'h00 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_finish: finish=%h slot1=%h terr=%b want 0002/00/0",
                  finish, data_out[15:8], timeout_err);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      set_core(9, 4'h2, 8'h99, 8'h00);
      req_rd[9] = 1'b1;
      tick();
      req_rd[9] = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || bif.b_read !== 1'b0 || finish !== '0 || bif.b_addr !== '0 || data_out !== '0) begin
         n_fail++;
         $display("FAIL rst_wait: busy=%b rd=%b finish=%h addr=%h want all 0",
                  busy, bif.b_read, finish, bif.b_addr);
      end
      bif.b_done  = 1'b1;
      bif.b_rdata = 8'h3A;
      tick();
      bif.b_done = 1'b0;
      tick();
      n_checks++;
      if (finish !== '0 || busy !== 1'b0 || data_out !== '0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_late_done: finish=%h busy=%b terr=%b want 0/0/0", finish, busy, timeout_err);
      end
   endtask

   task automatic test_random();
      logic [N*DW-1:0] exp_data;
      logic [N-1:0]    exp_fin;
      bit              exp_rd;
      bit              exp_wr;
      clear_inputs();
      bank_n = 4'h2;
      reset  = 1'b1;
      model_step();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) exp_data[k*DW +: DW] = m_data[k];
         exp_fin = (m_fin >= 0) ? (N'(1) << m_fin) : '0;
         exp_rd  = m_busy && m_age == 0 && !m_wr;
         exp_wr  = m_busy && m_age == 0 && m_wr;
         n_checks++;
         if (data_out !== exp_data) begin
            n_fail++; $display("FAIL rand_data_out cycle %0d: got %h want %h", c, data_out, exp_data);
         end
         n_checks++;
         if (finish !== exp_fin || timeout_err !== m_to || busy !== m_busy) begin
            n_fail++;
            $display("FAIL rand_status cycle %0d: finish=%h terr=%b busy=%b want %h/%b/%b",
                     c, finish, timeout_err, busy, exp_fin, m_to, m_busy);
         end
         n_checks++;
         if (bif.b_read !== exp_rd || bif.b_write !== exp_wr) begin
            n_fail++;
            $display("FAIL rand_strobe cycle %0d: rd=%b wr=%b want %b/%b", c, bif.b_read, bif.b_write, exp_rd, exp_wr);
         end
         if (m_busy) begin
            n_checks++;
            if (bif.b_addr !== m_row || bif.b_wdata !== m_wdata) begin
               n_fail++;
               $display("FAIL rand_cmd cycle %0d: addr=%h wdata=%h want %h/%h",
                        c, bif.b_addr, bif.b_wdata, m_row, m_wdata);
            end
         end
         // New inputs for the next edge.
         if ($urandom_range(0, 49) == 0) bank_n = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h5;
         for (int k = 0; k < N; k++) begin
            req_rd[k] = ($urandom_range(0, 5) == 0);
            req_wr[k] = ($urandom_range(0, 7) == 0);
            set_core(k, ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, 15)) : bank_n,
                     RW'($urandom), DW'($urandom));
         end
         bif.b_done  = ($urandom_range(0, 2) == 0);
         bif.b_rdata = DW'($urandom);
         reset       = ($urandom_range(0, 199) == 0);
         model_step();
         tick();
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      reset  = 1'b1;
      bank_n = 4'h2;
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_wrong_bank();
      test_timeout();
      test_write_priority();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
